// File: rtl/conv_addr_sequencer.sv
// Multi-filter convolution address sequencer: walks every window of one IF-map row
// against num_f consecutively stored filters, gated by circular-buffer occupancy and psum backpressure.
module conv_addr_sequencer #(
  parameter int IF_ADDR_W   = 4,
  parameter int FILT_ADDR_W = 4,
  parameter int SIZE_W      = 4,
  parameter int STRIDE_W    = 3,
  parameter int NF_W        = 2,
  parameter int PSUM_ADDR_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [STRIDE_W-1:0]    i_stride,
  input  logic [SIZE_W-1:0]      i_filter_size,
  input  logic [SIZE_W-1:0]      i_if_size,
  input  logic [NF_W-1:0]        i_num_f,
  input  logic [IF_ADDR_W:0]     i_if_wr_ptr,
  input  logic [FILT_ADDR_W:0]   i_filt_wr_ptr,
  input  logic                   i_psum_ready,
  output logic [IF_ADDR_W-1:0]   o_if_rd_addr,
  output logic [FILT_ADDR_W-1:0] o_filt_rd_addr,
  output logic                   o_mac_valid,
  output logic                   o_mac_first,
  output logic                   o_psum_wr_en,
  output logic [PSUM_ADDR_W-1:0] o_psum_wr_addr,
  output logic                   o_if_release,
  output logic [SIZE_W-1:0]      o_if_release_cnt,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_cfg_err
);

  localparam int IFP_W = IF_ADDR_W + 1;
  localparam int FP_W  = FILT_ADDR_W + 1;
  localparam int SW1   = SIZE_W + 1;
  localparam logic [IFP_W-1:0] IF_DEPTH   = {1'b1, {IF_ADDR_W{1'b0}}};
  localparam logic [FP_W-1:0]  FILT_DEPTH = {1'b1, {FILT_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [STRIDE_W-1:0]    r_stride;
  logic [SIZE_W-1:0]      r_fs;
  logic [SIZE_W-1:0]      r_if_size;
  logic [NF_W-1:0]        r_nf;
  logic [SIZE_W-1:0]      r_wo;
  logic [NF_W-1:0]        r_f;
  logic [SIZE_W-1:0]      r_k;
  logic [IFP_W-1:0]       r_if_row_ptr;
  logic [FP_W-1:0]        r_filt_row_ptr;
  logic [FP_W-1:0]        r_filt_base;
  logic [PSUM_ADDR_W-1:0] r_psum_addr;
  logic                   r_cfg_err;

  logic [IFP_W-1:0] w_if_pos;
  logic [FP_W-1:0]  w_filt_pos;
  logic [SW1-1:0]   w_wo_sum;
  logic             w_cfg_bad;
  logic             w_cfg_load;
  logic             w_mac_valid;
  logic             w_last_tap;
  logic             w_last_f;
  logic             w_more_win;
  logic             w_win_end;
  logic             w_row_end;

  // An entry is readable when the loader has written it and it has not been lapped.
  function automatic logic if_avail(input logic [IFP_W-1:0] wr, input logic [IFP_W-1:0] pos);
    logic [IFP_W-1:0] d;
    d = wr - pos;
    return (d != '0) && (d <= IF_DEPTH);
  endfunction

  function automatic logic filt_avail(input logic [FP_W-1:0] wr, input logic [FP_W-1:0] pos);
    logic [FP_W-1:0] d;
    d = wr - pos;
    return (d != '0) && (d <= FILT_DEPTH);
  endfunction

  assign w_if_pos   = r_if_row_ptr + IFP_W'(r_wo) + IFP_W'(r_k);
  assign w_filt_pos = r_filt_base + FP_W'(r_k);
  assign w_wo_sum   = SW1'(r_wo) + SW1'(r_stride) + SW1'(r_fs);

  assign w_cfg_bad  = (i_filter_size == '0) || (i_stride == '0) || (i_num_f == '0) ||
                      (i_filter_size > i_if_size);
  assign w_cfg_load = (r_state == S_IDLE) && i_start && !w_cfg_bad;

  assign w_mac_valid = (r_state == S_RUN) && if_avail(i_if_wr_ptr, w_if_pos) &&
                       filt_avail(i_filt_wr_ptr, w_filt_pos) && i_psum_ready;
  assign w_last_tap  = (r_k == r_fs - SIZE_W'(1));
  assign w_last_f    = (r_f == r_nf - NF_W'(1));
  assign w_more_win  = (w_wo_sum <= SW1'(r_if_size));
  assign w_win_end   = w_mac_valid && w_last_tap && w_last_f;
  assign w_row_end   = w_win_end && !w_more_win;

  assign o_if_rd_addr     = w_if_pos[IF_ADDR_W-1:0];
  assign o_filt_rd_addr   = w_filt_pos[FILT_ADDR_W-1:0];
  assign o_mac_valid      = w_mac_valid;
  assign o_mac_first      = w_mac_valid && (r_k == '0);
  assign o_psum_wr_en     = w_mac_valid && w_last_tap;
  assign o_psum_wr_addr   = r_psum_addr;
  assign o_if_release     = w_win_end;
  assign o_if_release_cnt = !w_win_end ? '0 :
                            (w_more_win ? SIZE_W'(r_stride) : (r_if_size - r_wo));
  assign o_busy           = (r_state == S_RUN);
  assign o_done           = (r_state == S_DONE);
  assign o_cfg_err        = r_cfg_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_cfg_load) w_state_nxt = S_RUN;
      S_RUN:   if (w_row_end)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Loop nest: window offset > filter > tap; everything holds unless a MAC issues.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stride       <= '0;
      r_fs           <= '0;
      r_if_size      <= '0;
      r_nf           <= '0;
      r_wo           <= '0;
      r_f            <= '0;
      r_k            <= '0;
      r_if_row_ptr   <= '0;
      r_filt_row_ptr <= '0;
      r_filt_base    <= '0;
      r_psum_addr    <= '0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && i_start && w_cfg_bad;
      if (w_cfg_load) begin
        r_stride    <= i_stride;
        r_fs        <= i_filter_size;
        r_if_size   <= i_if_size;
        r_nf        <= i_num_f;
        r_wo        <= '0;
        r_f         <= '0;
        r_k         <= '0;
        r_filt_base <= r_filt_row_ptr;
        r_psum_addr <= '0;
      end else if (w_mac_valid) begin
        if (!w_last_tap) begin
          r_k <= r_k + SIZE_W'(1);
        end else begin
          r_k         <= '0;
          r_psum_addr <= r_psum_addr + PSUM_ADDR_W'(1);
          if (!w_last_f) begin
            r_f         <= r_f + NF_W'(1);
            r_filt_base <= r_filt_base + FP_W'(r_fs);
          end else begin
            r_f <= '0;
            if (w_more_win) begin
              r_wo        <= r_wo + SIZE_W'(r_stride);
              r_filt_base <= r_filt_row_ptr;
            end else begin
              // filt_base already sits on the last filter, so one more fs lands past the set.
              r_if_row_ptr   <= r_if_row_ptr + IFP_W'(r_if_size);
              r_filt_row_ptr <= r_filt_base + FP_W'(r_fs);
              r_filt_base    <= r_filt_base + FP_W'(r_fs);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed bench for conv_addr_sequencer: a loop-nest model fills a scoreboard per row,
// and a negedge monitor pops and checks every issued MAC and IF release.
module tb_conv_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] stride = '0;
  logic [3:0] fsz = '0;
  logic [3:0] ifsz = '0;
  logic [1:0] nf = '0;
  logic [4:0] if_wr = '0;
  logic [4:0] filt_wr = '0;
  logic       psum_ready = 1'b1;

  logic [3:0] if_rd_addr;
  logic [3:0] filt_rd_addr;
  logic       mac_valid;
  logic       mac_first;
  logic       psum_wr_en;
  logic [5:0] psum_wr_addr;
  logic       if_release;
  logic [3:0] if_release_cnt;
  logic       busy;
  logic       done;
  logic       cfg_err;

  conv_addr_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start),
    .i_stride         (stride),
    .i_filter_size    (fsz),
    .i_if_size        (ifsz),
    .i_num_f          (nf),
    .i_if_wr_ptr      (if_wr),
    .i_filt_wr_ptr    (filt_wr),
    .i_psum_ready     (psum_ready),
    .o_if_rd_addr     (if_rd_addr),
    .o_filt_rd_addr   (filt_rd_addr),
    .o_mac_valid      (mac_valid),
    .o_mac_first      (mac_first),
    .o_psum_wr_en     (psum_wr_en),
    .o_psum_wr_addr   (psum_wr_addr),
    .o_if_release     (if_release),
    .o_if_release_cnt (if_release_cnt),
    .o_busy           (busy),
    .o_done           (done),
    .o_cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] p;
    logic [4:0] q;
    logic       first;
    logic       wr;
    logic [5:0] pa;
  } exp_t;

  exp_t       sbq[$];
  int         rq[$];
  logic [4:0] m_if = '0;
  logic [4:0] m_filt = '0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference loop nest: expected reads, strobes, psum indices and releases for one row.
  task automatic push_row(input int ifs, input int fs, input int str, input int n);
    exp_t e;
    int   wo;
    int   pa;
    bit   more;
    wo = 0;
    pa = 0;
    do begin
      for (int f = 0; f < n; f++) begin
        for (int k = 0; k < fs; k++) begin
          e.p     = 5'(int'(m_if) + wo + k);
          e.q     = 5'(int'(m_filt) + f * fs + k);
          e.first = (k == 0);
          e.wr    = (k == fs - 1);
          e.pa    = 6'(pa);
          sbq.push_back(e);
          if (k == fs - 1) pa++;
        end
      end
      more = (wo + str + fs <= ifs);
      rq.push_back(more ? str : ifs - wo);
      if (more) wo += str;
    end while (more);
    m_if   = 5'(int'(m_if) + ifs);
    m_filt = 5'(int'(m_filt) + n * fs);
  endtask

  task automatic set_cfg(input int ifs, input int fs, input int str, input int n);
    ifsz   = 4'(ifs);
    fsz    = 4'(fs);
    stride = 3'(str);
    nf     = 2'(n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 600) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run_row(input int ifs, input int fs, input int str, input int n,
                         input bit pre, output int cyc);
    set_cfg(ifs, fs, str, n);
    if (pre) begin
      if_wr   = 5'(int'(m_if) + ifs);
      filt_wr = 5'(int'(m_filt) + n * fs);
    end
    push_row(ifs, fs, str, n);
    pulse_start();
    wait_done(cyc);
    check("sb_drained", sbq.size(), 0);
    check("rel_drained", rq.size(), 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after_row", busy, 0);
  endtask

  exp_t       me;
  logic [4:0] md;

  always @(negedge clk) begin
    if (mac_valid) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        check("if_rd_addr", if_rd_addr, me.p[3:0]);
        check("filt_rd_addr", filt_rd_addr, me.q[3:0]);
        check("mac_first", mac_first, me.first);
        check("psum_wr_en", psum_wr_en, me.wr);
        check("psum_wr_addr", psum_wr_addr, me.pa);
        md = if_wr - me.p;
        check("if_avail", (md >= 5'd1) && (md <= 5'd16), 1);
        md = filt_wr - me.q;
        check("filt_avail", (md >= 5'd1) && (md <= 5'd16), 1);
      end
    end
    if (if_release) begin
      check("rel_expected", rq.size() != 0, 1);
      if (rq.size() != 0) check("if_release_cnt", if_release_cnt, rq.pop_front());
    end
  end

  initial begin
    int   cyc;
    exp_t h;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_mac_valid", mac_valid, 0);
    check("rst_psum_wr_en", psum_wr_en, 0);
    check("rst_psum_addr", psum_wr_addr, 0);
    check("rst_release", if_release, 0);
    check("rst_if_addr", if_rd_addr, 0);
    check("rst_filt_addr", filt_rd_addr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single filter, stride 1, data prewritten: 18 back-to-back taps
    run_row(8, 3, 1, 1, 1'b1, cyc);
    check("t1_cycles", cyc, 18);

    // Stride 2 with a partial final release; a mid-row start is ignored
    fork
      run_row(7, 3, 2, 1, 1'b1, cyc);
      begin
        repeat (3) @(posedge clk);
        #1 set_cfg(4, 1, 1, 2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check("t2_cycles", cyc, 9);

    // psum backpressure holds the sequencer in place
    fork
      run_row(8, 3, 1, 1, 1'b1, cyc);
      begin
        repeat (4) @(posedge clk);
        #1 psum_ready = 1'b0;
        repeat (4) begin
          @(posedge clk);
          #1;
          h = sbq[0];
          check("stall_mac_valid", mac_valid, 0);
          check("stall_if_addr", if_rd_addr, h.p[3:0]);
          check("stall_filt_addr", filt_rd_addr, h.q[3:0]);
          check("stall_psum_addr", psum_wr_addr, h.pa);
        end
        psum_ready = 1'b1;
      end
    join
    check("stall_cycles", cyc, 22);

    // Asynchronous reset in the middle of a row
    set_cfg(8, 3, 1, 1);
    if_wr   = 5'(int'(m_if) + 8);
    filt_wr = 5'(int'(m_filt) + 3);
    push_row(8, 3, 1, 1);
    pulse_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mac_valid", mac_valid, 0);
    sbq.delete();
    rq.delete();
    m_if   = '0;
    m_filt = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", done, 0);
      check("midrst_if_ptr", if_rd_addr, 0);
      check("midrst_filt_ptr", filt_rd_addr, 0);
    end

    // Two filters interleaved per window, from cleared pointers
    run_row(4, 2, 2, 2, 1'b1, cyc);
    check("t3_cycles", cyc, 8);

    // Slow loader: one IF entry every 3 cycles
    if_wr   = m_if;
    filt_wr = 5'(int'(m_filt) + 3);
    fork
      run_row(6, 3, 1, 1, 1'b0, cyc);
      begin
        repeat (6) begin
          repeat (3) @(posedge clk);
          #1 if_wr = if_wr + 5'd1;
        end
      end
    join
    check("t4_throttled", cyc >= 18, 1);

    // Three rows crossing the pointer wrap for both buffers, no false stalls
    for (int r = 0; r < 3; r++) begin
      run_row(15, 2, 3, 3, 1'b1, cyc);
      check("t5_cycles", cyc, 30);
    end

    // Bad configurations
    set_cfg(3, 4, 1, 1);
    pulse_start();
    check("cfg_fs_gt_if", cfg_err, 1);
    check("cfg_busy", busy, 0);
    @(posedge clk);
    #1;
    check("cfg_err_pulse", cfg_err, 0);
    check("cfg_stay_idle", busy, 0);
    set_cfg(8, 3, 0, 1);
    pulse_start();
    check("cfg_stride0", cfg_err, 1);
    set_cfg(8, 3, 1, 0);
    pulse_start();
    check("cfg_nf0", cfg_err, 1);
    set_cfg(8, 0, 1, 1);
    pulse_start();
    check("cfg_fs0", cfg_err, 1);
    @(posedge clk);
    #1;
    check("cfg_final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
